// File: rtl/square_wave_pkg.sv
// square_wave_pkg: shared types and constants for the square-wave meter.
//   meter_state_t : measurement FSM states
//   METER_W       : default counter width
package square_wave_pkg;
   typedef enum logic [1:0] {IDLE, MEAS_HIGH, MEAS_LOW} meter_state_t;
   localparam int METER_W = 16;
endpackage

// File: rtl/square_wave_meter_if.sv
// square_wave_meter_if: measurement bus between a wave source/consumer and the meter.
//   waveIn, clear                              : driven by master (source side)
//   highCount, lowCount, periodCount,
//   measValid, overflow                        : driven by slave (meter)
interface square_wave_meter_if
   import square_wave_pkg::*;
#(
   parameter int W = METER_W
);
   logic         waveIn;
   logic         clear;
   logic [W-1:0] highCount;
   logic [W-1:0] lowCount;
   logic [W:0]   periodCount;
   logic         measValid;
   logic         overflow;
   modport master (
      output waveIn, clear,
      input  highCount, lowCount, periodCount, measValid, overflow
   );
   modport slave (
      input  waveIn, clear,
      output highCount, lowCount, periodCount, measValid, overflow
   );
endinterface

// File: rtl/edge_sync.sv
// edge_sync: multi-flop synchronizer for an asynchronous input plus edge detection.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   d_i     : asynchronous input
//   s_o     : synchronized level
//   rise_o  : one-cycle pulse on synchronized 0->1
//   fall_o  : one-cycle pulse on synchronized 1->0
module edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic s_o,
   output logic rise_o,
   output logic fall_o
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   p_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
         p_q    <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         p_q    <= sync_q[SYNC_STAGES-1];
      end
   end
   assign s_o    = sync_q[SYNC_STAGES-1];
   assign rise_o = s_o & ~p_q;
   assign fall_o = ~s_o & p_q;
endmodule

// File: rtl/square_wave_meter.sv
// square_wave_meter: measures high/low time and period of a square wave in clock cycles.
//   CLK   : clock, rising edge
//   RST_N : asynchronous active-low reset
//   bus   : slave side of square_wave_meter_if
//           in : waveIn (async square wave), clear (sync restart)
//           out: highCount, lowCount, periodCount, measValid (1-cycle strobe), overflow (sticky)
module square_wave_meter
   import square_wave_pkg::*;
#(
   parameter int W           = METER_W,
   parameter int SYNC_STAGES = 2
) (
   input logic                CLK,
   input logic                RST_N,
   square_wave_meter_if.slave bus
);
   localparam logic [W-1:0] CNT_MAX = '1;
   localparam logic [W-1:0] CNT_ONE = W'(1);
   meter_state_t state_q, state_d;
   logic [W-1:0] cnt_q, cnt_d, hi_tmp_q, hi_tmp_d, high_q, high_d, low_q, low_d, cnt_inc;
   logic [W:0]   period_q, period_d;
   logic         valid_q, valid_d, ovf_q, ovf_d;
   logic         s, rise, fall;
   edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_i  (CLK),
      .rst_ni (RST_N),
      .d_i    (bus.waveIn),
      .s_o    (s),
      .rise_o (rise),
      .fall_o (fall)
   );
   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_tmp_d = hi_tmp_q;
      high_d   = high_q;
      low_d    = low_q;
      period_d = period_q;
      valid_d  = 1'b0;
      ovf_d    = ovf_q;
      case (state_q)
         IDLE: begin
            cnt_d   = rise ? CNT_ONE : '0;
            state_d = rise ? MEAS_HIGH : IDLE;
         end
         MEAS_HIGH: begin
            // the fall cycle is the first low cycle, so low counting restarts at 1
            cnt_d    = fall ? CNT_ONE : cnt_inc;
            hi_tmp_d = fall ? cnt_q : hi_tmp_q;
            state_d  = fall ? MEAS_LOW : MEAS_HIGH;
         end
         MEAS_LOW: begin
            cnt_d = rise ? CNT_ONE : cnt_inc;
            if (rise) begin
               high_d   = hi_tmp_q;
               low_d    = cnt_q;
               period_d = {1'b0, hi_tmp_q} + {1'b0, cnt_q};
               valid_d  = 1'b1;
               state_d  = MEAS_HIGH;
            end
         end
         default: state_d = IDLE;
      endcase
      if (cnt_d == CNT_MAX) ovf_d = 1'b1;
      // clear overrides any edge or completion seen in the same cycle
      if (bus.clear) begin
         state_d  = IDLE;
         cnt_d    = '0;
         hi_tmp_d = '0;
         high_d   = '0;
         low_d    = '0;
         period_d = '0;
         valid_d  = 1'b0;
         ovf_d    = 1'b0;
      end
   end
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         hi_tmp_q <= '0;
         high_q   <= '0;
         low_q    <= '0;
         period_q <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_tmp_q <= hi_tmp_d;
         high_q   <= high_d;
         low_q    <= low_d;
         period_q <= period_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
      end
   end
   assign bus.highCount   = high_q;
   assign bus.lowCount    = low_q;
   assign bus.periodCount = period_q;
   assign bus.measValid   = valid_q;
   assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_square_wave_meter.sv
// tb_square_wave_meter: scoreboard bench driving a W=16 and a W=4 meter with the same wave.
module tb_square_wave_meter;
   import square_wave_pkg::*;
   localparam int SYNC = 2;
   localparam int MAX16 = 65535;
   localparam int MAX4 = 15;

   typedef struct {
      int h16, l16, p16, h4, l4, p4;
   } exp_t;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   logic wave_in = 1'b0;
   logic clear = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   mv_count = 0;
   bit   mon_en = 0;

   square_wave_meter_if #(.W(16)) b16 ();
   square_wave_meter_if #(.W(4))  b4 ();
   assign b16.waveIn = wave_in;
   assign b16.clear  = clear;
   assign b4.waveIn  = wave_in;
   assign b4.clear   = clear;

   square_wave_meter #(.W(16), .SYNC_STAGES(SYNC)) u16 (.CLK(CLK), .RST_N(RST_N), .bus(b16));
   square_wave_meter #(.W(4),  .SYNC_STAGES(SYNC)) u4  (.CLK(CLK), .RST_N(RST_N), .bus(b4));

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int x, input int m);
      return (x > m) ? m : x;
   endfunction

   function automatic exp_t mk(input int h, input int l);
      exp_t e;
      e.h16 = sat(h, MAX16); e.l16 = sat(l, MAX16); e.p16 = e.h16 + e.l16;
      e.h4  = sat(h, MAX4);  e.l4  = sat(l, MAX4);  e.p4  = e.h4 + e.l4;
      return e;
   endfunction

   // Reference model: run lengths of the synchronized level, measured rise to rise.
   exp_t            q[$];
   exp_t            cur_out = '{0, 0, 0, 0, 0, 0};
   logic [SYNC-1:0] msync = '0;
   logic            mp = 1'b0;
   logic            s_m, r_m, f_m;
   bit              armed = 0, ovf16 = 0, ovf4 = 0;
   int              cur = 0, last_hi = 0;

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         msync   <= '0;
         mp      <= 1'b0;
         armed   <= 0;
         cur     <= 0;
         last_hi <= 0;
         ovf16   <= 0;
         ovf4    <= 0;
         cur_out <= '{0, 0, 0, 0, 0, 0};
         q.delete();
      end else begin
         s_m = msync[SYNC-1];
         r_m = s_m & ~mp;
         f_m = ~s_m & mp;
         msync <= {msync[SYNC-2:0], wave_in};
         mp    <= s_m;
         if (clear) begin
            armed   <= 0;
            cur     <= 0;
            last_hi <= 0;
            ovf16   <= 0;
            ovf4    <= 0;
            cur_out <= '{0, 0, 0, 0, 0, 0};
         end else if (armed && (r_m || f_m)) begin
            cur <= 1;
            if (f_m) last_hi <= cur;
            else begin
               q.push_back(mk(last_hi, cur));
               cur_out <= mk(last_hi, cur);
            end
         end else if (armed) begin
            cur <= cur + 1;
            if (cur + 1 >= MAX16) ovf16 <= 1;
            if (cur + 1 >= MAX4) ovf4 <= 1;
         end else if (r_m) begin
            armed <= 1;
            cur   <= 1;
         end
      end
   end

   // Monitor: pops an expectation whenever the DUT strobes, and checks held outputs every cycle.
   exp_t e;
   always @(negedge CLK) begin
      if (mon_en) begin
         if (b16.measValid || b4.measValid) begin
            if (b16.measValid) mv_count++;
            chk("valid_expected", 64'(q.size() > 0), 1);
            if (q.size() > 0) begin
               e = q.pop_front();
               chk("mv16", b16.measValid, 1);
               chk("mv4", b4.measValid, 1);
               chk("pop_h16", b16.highCount, e.h16);
               chk("pop_l16", b16.lowCount, e.l16);
               chk("pop_p16", b16.periodCount, e.p16);
               chk("pop_h4", b4.highCount, e.h4);
               chk("pop_l4", b4.lowCount, e.l4);
               chk("pop_p4", b4.periodCount, e.p4);
            end
         end else begin
            chk("valid_missing", q.size(), 0);
            q.delete();
         end
         chk("hold_h16", b16.highCount, cur_out.h16);
         chk("hold_l16", b16.lowCount, cur_out.l16);
         chk("hold_p16", b16.periodCount, cur_out.p16);
         chk("hold_h4", b4.highCount, cur_out.h4);
         chk("hold_l4", b4.lowCount, cur_out.l4);
         chk("hold_p4", b4.periodCount, cur_out.p4);
         chk("ovf16", b16.overflow, ovf16);
         chk("ovf4", b4.overflow, ovf4);
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic wave(input int h, input int l, input int n);
      repeat (n) begin
         wave_in = 1'b1;
         step(h);
         wave_in = 1'b0;
         step(l);
      end
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      step(1);
      clear = 1'b0;
   endtask

   task automatic chk_zero(input string name);
      chk({name, "_h16"}, b16.highCount, 0);
      chk({name, "_l16"}, b16.lowCount, 0);
      chk({name, "_p16"}, b16.periodCount, 0);
      chk({name, "_mv16"}, b16.measValid, 0);
      chk({name, "_ovf16"}, b16.overflow, 0);
      chk({name, "_h4"}, b4.highCount, 0);
      chk({name, "_ovf4"}, b4.overflow, 0);
   endtask

   initial begin
      int n, mv0;
      step(1);
      mon_en = 1;
      step(2);
      chk_zero("reset");
      RST_N = 1'b1;
      step(50);
      chk_zero("idle");
      chk("idle_no_valid", mv_count, 0);

      // steady 20/10 wave; first report 3 cycles after the second rise
      wave(20, 10, 1);
      wave_in = 1'b1;
      n = 0;
      do begin
         step(1);
         n++;
      end while (!b16.measValid && n < 10);
      chk("first_latency", n, 3);
      step(20 - n);
      wave_in = 1'b0;
      step(10);
      wave(20, 10, 4);
      chk("steady_h", b16.highCount, 20);
      chk("steady_l", b16.lowCount, 10);
      chk("steady_p", b16.periodCount, 30);
      chk("steady_count", mv_count, 5);

      // minimum widths
      step(5);
      pulse_clear();
      wave(1, 1, 6);
      chk("min11_p", b16.periodCount, 2);
      wave(1, 7, 4);
      chk("min17_l", b16.lowCount, 7);
      chk("min17_p", b16.periodCount, 8);

      // saturation on the W=4 meter
      pulse_clear();
      step(5);
      wave_in = 1'b1;
      step(20);
      wave_in = 1'b0;
      step(3);
      wave_in = 1'b1;
      step(5);
      chk("sat_h4", b4.highCount, 15);
      chk("sat_l4", b4.lowCount, 3);
      chk("sat_p4", b4.periodCount, 18);
      chk("sat_ovf4", b4.overflow, 1);
      chk("sat_h16", b16.highCount, 20);
      chk("sat_ovf16", b16.overflow, 0);
      step(10);
      chk("sat_ovf4_sticky", b4.overflow, 1);
      wave_in = 1'b0;
      step(5);
      pulse_clear();
      chk("sat_ovf4_cleared", b4.overflow, 0);

      // clear in the middle of a high phase
      wave(8, 8, 3);
      wave_in = 1'b1;
      step(4);
      pulse_clear();
      chk_zero("midclr");
      step(4);
      wave_in = 1'b0;
      step(8);
      mv0 = mv_count;
      wave(8, 8, 3);
      chk("midclr_reports", mv_count - mv0, 2);
      chk("midclr_h", b16.highCount, 8);
      chk("midclr_p", b16.periodCount, 16);

      // clear on the exact cycle a report would fire
      wave(8, 8, 2);
      wave_in = 1'b1;
      step(2);
      pulse_clear();
      chk_zero("coinclr");
      chk("coinclr_state", u16.state_q, IDLE);
      step(7);
      wave_in = 1'b0;
      step(8);
      wave(8, 8, 2);

      // asynchronous reset between clock edges
      wave(8, 8, 3);
      wave_in = 1'b1;
      step(3);
      chk("pre_arst_h", b16.highCount, 8);
      #1;
      RST_N = 1'b0;
      #1;
      chk_zero("arst");
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
      wave_in = 1'b0;
      step(5);

      // randomized run lengths with occasional clears
      for (int i = 0; i < 120; i++) begin
         wave_in = ~wave_in;
         step($urandom_range(1, 24));
         if ($urandom_range(0, 9) == 0) pulse_clear();
      end
      step(10);
      chk("final_queue_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/square_wave_meter.md
Name: square_wave_meter

Overview:
- Downstream consumer of the programmable square-wave generator's waveOut.
- Measures the high time and low time of each waveform period in CLK cycles, and reports the period.
- Raises a single-cycle valid strobe for each completed period.
- Used in self-checking benches and on-board readback to confirm that programmed M/N values yield the intended duty cycle.

Parameters:
- W, 16, width of the high and low counters and their outputs.
- SYNC_STAGES, 2, number of flip-flops synchronizing waveIn (minimum 2).

Ports:
- CLK  input  1  system clock, all logic on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- waveIn  input  1  square wave under measurement. May be asynchronous to CLK.
- clear  input  1  synchronous restart of measurement, active high.
- highCount  output  W  cycles waveIn was high in the last completed period.
- lowCount  output  W  cycles waveIn was low in the last completed period.
- periodCount  output  W+1  highCount + lowCount for the same period.
- measValid  output  1  one-cycle pulse when the three counts above update.
- overflow  output  1  sticky flag: a counter saturated since the last reset or clear.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - all outputs 0;
  - synchronizer and edge register 0;
  - internal cnt and hiTmp 0;
  - FSM in IDLE.
- Synchronizer:
  - waveIn passes through SYNC_STAGES flops to give s.
  - p is s delayed by one cycle.
  - rise = s & ~p; fall = ~s & p.
- FSM states:
  - IDLE:
    - cnt held at 0.
    - On rise: cnt <= 1, go to MEAS_HIGH.
    - A fall seen in IDLE is ignored; measurement always starts on a rising edge.
  - MEAS_HIGH:
    - While s=1: cnt <= cnt+1, saturating.
    - On fall: hiTmp <= cnt, cnt <= 1, go to MEAS_LOW.
  - MEAS_LOW:
    - While s=0: cnt <= cnt+1, saturating.
    - On rise: highCount <= hiTmp, lowCount <= cnt, periodCount <= hiTmp + cnt (zero-extended to W+1), measValid <= 1, cnt <= 1, go to MEAS_HIGH.
- Counting semantics:
  - highCount equals the exact number of cycles s was 1.
  - lowCount equals the exact number of cycles s was 0.
  - A stable input with period H+L cycles yields highCount=H and lowCount=L.
- Latency:
  - measValid is asserted the cycle after the synchronized rising edge that ends a period.
  - That is SYNC_STAGES+1 cycles after the waveIn transition sampled on a CLK edge.
  - Outputs hold their values until the next measValid.
- measValid is high for exactly one cycle per completed period. It is never asserted for the first partial period after reset or clear.
- Saturation:
  - cnt stops at 2^W-1 and does not wrap.
  - On reaching that value, overflow <= 1.
  - The saturated value is reported normally at the end of the period.
  - overflow clears only on reset or clear.
- A stuck-high or stuck-low input produces no further measValid. Counts hold their last values, and cnt saturates and sets overflow.
- clear:
  - Same-cycle effect as reset, except it is synchronous: FSM to IDLE, cnt, hiTmp, outputs, measValid and overflow to 0. Synchronizer flops are not cleared.
  - clear has priority over a simultaneous rise or fall, and over completion of a measurement in the same cycle (no measValid that cycle).
- Reset or clear mid-period discards the partial measurement. The first report follows one full rise-to-rise period after the next rising edge.
- A minimum pulse width of 1 cycle (H=1 or L=1) is measured correctly.

Decomposition:
- Package square_wave_pkg:
  - FSM enum meter_state_t {IDLE, MEAS_HIGH, MEAS_LOW};
  - default width constant METER_W = 16.
- One sub-module, edge_sync: parameterized SYNC_STAGES synchronizer plus delay register, producing s, rise and fall. It is reusable for other asynchronous inputs in the lab.
- The FSM, counters and output registers stay in square_wave_meter.

Test Plan:
- Reset and idle:
  - Stimulus: RST_N low for 3 cycles, waveIn=0 for 50 cycles.
  - Required response: all outputs 0, no measValid.
- Steady wave, H=20 L=10, at least 4 periods:
  - Required: from the second rise onward, measValid every 30 cycles with highCount=20, lowCount=10, periodCount=30.
  - The first measValid occurs 3 cycles after the second waveIn rise.
- Minimum widths, H=1 L=1, and asymmetric H=1 L=7:
  - Required: counts 1/1/2 and 1/7/8 respectively, one pulse per period.
- Saturation with W=4:
  - Stimulus: waveIn high 20 cycles, then low 3 cycles, then rise.
  - Required: highCount=15, lowCount=3, periodCount=18, overflow=1 and stays 1 until clear.
- clear mid-period:
  - Stimulus: H=8 L=8 wave, pulse clear in the middle of a high phase.
  - Required: outputs and overflow zero next cycle. No measValid until one full period after the next rise, then 8/8/16.
- Clear coincident with period end:
  - Stimulus: assert clear in the exact cycle measValid would fire.
  - Required: no measValid, outputs 0, FSM in IDLE.
- Asynchronous reset mid-measurement:
  - Stimulus: drop RST_N between clock edges.
  - Required: outputs 0 immediately, not waiting for a clock edge.
